dmem_responder: RTL

- Multi-cycle data-memory responder on the MEM-stage load/store request interface; the pipeline's MEM stage is the initiator.
- Accepts one request at a time and holds it for LATENCY cycles.
- Returns load data with byte/half sign or zero extension, and commits stores.
- Drives mem_stall to the hazard logic so PC, IF/ID, ID/EX and EX/MEM hold while an access is outstanding.

---
 rtl/dmem_responder_pkg.sv | 49 ++++
 rtl/dmem_responder_lsu_align.sv | 42 ++++
 rtl/dmem_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: access-size encodings, the latched
// request record, FSM states and the helper that classifies an access width.
package dmem_responder_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        ACC_B,
        ACC_H,
        ACC_W
    } acc_width_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_e;

    typedef struct packed {
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Loads treat 100/101 as unsigned byte/half; stores only know 000/001 and fall back to word.
    function automatic acc_width_e access_width(input logic [2:0] size, input logic is_store);
        acc_width_e w;
        if (is_store) begin
            if (size == MEM_B)      w = ACC_B;
            else if (size == MEM_H) w = ACC_H;
            else                    w = ACC_W;
        end else begin
            case (size[1:0])
                2'b00:   w = ACC_B;
                2'b01:   w = ACC_H;
                default: w = ACC_W;
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_responder_lsu_align.sv
// Lane steering for one access: byte-enable mask, replicated store data and
// sign/zero-extended load data for the given word, byte offset and funct3 size.
module lsu_align
    import dmem_responder_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  size_i,
    input  logic        is_store_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o
);
    acc_width_e  width;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign width    = access_width(size_i, is_store_i);
    assign byte_sel = word_i[{off_i, 3'b000} +: 8];
    assign half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    // size_i[2] selects zero extension for LBU/LHU.
    always_comb begin
        be_o      = 4'b1111;
        st_data_o = word_i;
        ld_data_o = word_i;
        case (width)
            ACC_B: begin
                be_o      = 4'b0001 << off_i;
                st_data_o = {4{word_i[7:0]}};
                ld_data_o = size_i[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            ACC_H: begin
                be_o      = off_i[1] ? 4'b1100 : 4'b0011;
                st_data_o = {2{word_i[15:0]}};
                ld_data_o = size_i[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Optional macro DMEM_ERR_EN: report misaligned/out-of-range accesses on resp_err instead of force-aligning.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
`ifdef DMEM_ERR_EN
    output logic        resp_err,
`endif
    output logic        mem_stall
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t         req_q;
    logic [31:0]      rdata_q;
    logic [31:0]      mem_q [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [1:0]       off_eff;
    acc_width_e       width;
    logic             oor, drop, err_flag, drive_rdata;
    logic [3:0]       st_be, ld_be;
    logic [31:0]      st_data, st_ld, ld_st, ld_data, load_val;
    logic             unused_align;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // The counter is loaded with LATENCY-1 so RESP lands LATENCY cycles after acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        mem_stall  = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
`ifdef DMEM_ERR_EN
        resp_err   = (state_q == RESP) && err_flag;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if ((state_q == RESP) && drive_rdata) rdata_q <= load_val;
        end
    end

    always_ff @(posedge clock) begin
        if ((state_q == IDLE) && req_valid)
            req_q <= '{write: req_write, size: req_size, addr: req_addr, wdata: req_wdata};
    end

    assign idx   = req_q.addr[IDX_W+1:2];
    assign oor   = |req_q.addr[31:IDX_W+2];
    assign width = access_width(req_q.size, req_q.write);

`ifdef DMEM_ERR_EN
    logic misalign;
    assign misalign = ((width == ACC_H) && req_q.addr[0]) ||
                      ((width == ACC_W) && (req_q.addr[1:0] != 2'b00));
    assign off_eff  = req_q.addr[1:0];
    assign err_flag = oor || misalign;
    assign drop     = err_flag;
`else
    always_comb begin
        case (width)
            ACC_B:   off_eff = req_q.addr[1:0];
            ACC_H:   off_eff = {req_q.addr[1], 1'b0};
            default: off_eff = 2'b00;
        endcase
    end
    assign err_flag = 1'b0;
    assign drop     = oor;
`endif

    lsu_align u_store_align (
        .word_i     (req_q.wdata),
        .off_i      (off_eff),
        .size_i     (req_q.size),
        .is_store_i (1'b1),
        .be_o       (st_be),
        .st_data_o  (st_data),
        .ld_data_o  (st_ld)
    );

    lsu_align u_load_align (
        .word_i     (mem_q[idx]),
        .off_i      (off_eff),
        .size_i     (req_q.size),
        .is_store_i (1'b0),
        .be_o       (ld_be),
        .st_data_o  (ld_st),
        .ld_data_o  (ld_data)
    );

    assign unused_align = ^{ld_be, ld_st, st_ld};

    // Store responses leave resp_rdata holding, except an errored access which reports zero.
    assign load_val    = drop ? 32'h0 : ld_data;
    assign drive_rdata = !req_q.write || err_flag;
    assign resp_rdata  = ((state_q == RESP) && drive_rdata) ? load_val : rdata_q;

    always_ff @(posedge clock) begin
        if ((state_q == RESP) && req_q.write && !drop) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mem_q[idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

endmodule
